// File: rtl/hs32_mem_arbiter_pkg.sv
// ============================================================================
// Module      : hs32_mem_arbiter_pkg
// Description : Shared encodings and grant helper for the hs32 memory arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hs32_mem_arbiter_pkg;

    localparam logic c_st_idle = 1'b0;
    localparam logic c_st_busy = 1'b1;

    localparam logic c_gnt_f   = 1'b0;
    localparam logic c_gnt_e   = 1'b1;

    // With both pending, the requester that did not win last time goes next.
    function automatic logic pick_grant(input logic pf, input logic pe, input logic last);
        if (pf && pe) begin
            return (last == c_gnt_f) ? c_gnt_e : c_gnt_f;
        end else if (pe) begin
            return c_gnt_e;
        end
        return c_gnt_f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hs32_mem_arbiter_slot.sv
// ============================================================================
// Module      : hs32_mem_arbiter_slot
// Description : One-deep pending-request latch; load wins over clear/drop.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hs32_mem_arbiter_slot #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic          drop,
    input  logic [AW-1:0] addr_in,
    input  logic          rw_in,
    input  logic [DW-1:0] data_in,
    output logic          pend,
    output logic [AW-1:0] addr_out,
    output logic          rw_out,
    output logic [DW-1:0] data_out
);

    logic          r_pend;
    logic [AW-1:0] r_addr;
    logic          r_rw;
    logic [DW-1:0] r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
            r_addr <= '0;
            r_rw   <= 1'b0;
            r_data <= '0;
        end else if (load) begin
            r_pend <= 1'b1;
            r_addr <= addr_in;
            r_rw   <= rw_in;
            r_data <= data_in;
        end else if (clear || drop) begin
            r_pend <= 1'b0;
        end
    end

    assign pend     = r_pend;
    assign addr_out = r_addr;
    assign rw_out   = r_rw;
    assign data_out = r_data;

endmodule

`default_nettype wire

// File: rtl/hs32_mem_arbiter.sv
// ============================================================================
// Module      : hs32_mem_arbiter
// Description : Arbitrates fetch and exec requests onto one valid/ready port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hs32_mem_arbiter
    import hs32_mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_f,
    input  logic [AW-1:0] addr_f,
    output logic          rdy_f,
    output logic [DW-1:0] dtr_f,
    output logic          err_f,
    input  logic          flush,
    input  logic          req_e,
    input  logic          rw_e,
    input  logic [AW-1:0] addr_e,
    input  logic [DW-1:0] dtw_e,
    output logic          rdy_e,
    output logic [DW-1:0] dtr_e,
    output logic          err_e,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] dtw,
    output logic          rw,
    output logic          valid,
    input  logic          ready,
    input  logic [DW-1:0] dread
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_tmo_last = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic          r_state;
    logic          r_gnt;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_fdrop;
    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dtw;
    logic          r_rw;
    logic          r_rdy_f;
    logic          r_err_f;
    logic [DW-1:0] r_dtr_f;
    logic          r_rdy_e;
    logic          r_err_e;
    logic [DW-1:0] r_dtr_e;

    logic          w_pend_f;
    logic          w_pend_e;
    logic [AW-1:0] w_addr_f;
    logic [AW-1:0] w_addr_e;
    logic          w_rw_f;
    logic          w_rw_e;
    logic [DW-1:0] w_dat_f;
    logic [DW-1:0] w_dat_e;
    logic          w_busy_f;
    logic          w_busy_e;
    logic          w_acc_f;
    logic          w_acc_e;
    logic          w_pf;
    logic          w_state_nxt;
    logic          w_grant;
    logic          w_sel;
    logic          w_done;
    logic          w_tmo;
    logic          w_end;
    logic          w_resp_f;
    logic          w_resp_e;
    logic [DW-1:0] w_rdata;

    assign w_busy_f = (r_state == c_st_busy) && (r_gnt == c_gnt_f);
    assign w_busy_e = (r_state == c_st_busy) && (r_gnt == c_gnt_e);
    assign w_acc_f  = req_f && !w_pend_f && !w_busy_f;
    assign w_acc_e  = req_e && !w_pend_e && !w_busy_e;
    // A fetch that is being flushed this cycle must not win arbitration.
    assign w_pf     = w_pend_f && !flush;

    hs32_mem_arbiter_slot #(.AW(AW), .DW(DW)) u_slot_f (
        .clk      (clk),
        .reset    (reset),
        .load     (w_acc_f),
        .clear    (w_grant && (w_sel == c_gnt_f)),
        .drop     (flush),
        .addr_in  (addr_f),
        .rw_in    (1'b0),
        .data_in  ({DW{1'b0}}),
        .pend     (w_pend_f),
        .addr_out (w_addr_f),
        .rw_out   (w_rw_f),
        .data_out (w_dat_f)
    );

    hs32_mem_arbiter_slot #(.AW(AW), .DW(DW)) u_slot_e (
        .clk      (clk),
        .reset    (reset),
        .load     (w_acc_e),
        .clear    (w_grant && (w_sel == c_gnt_e)),
        .drop     (1'b0),
        .addr_in  (addr_e),
        .rw_in    (rw_e),
        .data_in  (dtw_e),
        .pend     (w_pend_e),
        .addr_out (w_addr_e),
        .rw_out   (w_rw_e),
        .data_out (w_dat_e)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = r_gnt;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_pf || w_pend_e) begin
                    w_grant     = 1'b1;
                    w_sel       = pick_grant(w_pf, w_pend_e, r_last);
                    w_state_nxt = c_st_busy;
                end
            end
            default: begin
                // ready in the expiry cycle completes normally.
                if (ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if ((TIMEOUT > 0) && (r_cnt == c_tmo_last)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    always_comb begin
        w_end    = w_done || w_tmo;
        w_resp_f = w_end && (r_gnt == c_gnt_f) && !(r_fdrop || flush);
        w_resp_e = w_end && (r_gnt == c_gnt_e);
        w_rdata  = w_done ? dread : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt   <= c_gnt_f;
            r_last  <= c_gnt_f;
            r_cnt   <= '0;
            r_fdrop <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_dtw   <= '0;
            r_rw    <= 1'b0;
            r_rdy_f <= 1'b0;
            r_err_f <= 1'b0;
            r_dtr_f <= '0;
            r_rdy_e <= 1'b0;
            r_err_e <= 1'b0;
            r_dtr_e <= '0;
        end else begin
            r_rdy_f <= w_resp_f;
            r_err_f <= w_resp_f && w_tmo;
            r_rdy_e <= w_resp_e;
            r_err_e <= w_resp_e && w_tmo;
            if (w_resp_f) begin
                r_dtr_f <= w_rdata;
            end
            if (w_resp_e) begin
                r_dtr_e <= w_rdata;
            end
            if (w_grant) begin
                r_gnt   <= w_sel;
                r_last  <= w_sel;
                r_cnt   <= '0;
                r_fdrop <= 1'b0;
                r_valid <= 1'b1;
                r_addr  <= (w_sel == c_gnt_e) ? w_addr_e : w_addr_f;
                r_rw    <= (w_sel == c_gnt_e) ? w_rw_e   : w_rw_f;
                r_dtw   <= (w_sel == c_gnt_e) ? w_dat_e  : w_dat_f;
            end else if (w_end) begin
                r_valid <= 1'b0;
                r_fdrop <= 1'b0;
            end else if (r_state == c_st_busy) begin
                r_cnt <= r_cnt + CW'(1);
                if (flush && (r_gnt == c_gnt_f)) begin
                    r_fdrop <= 1'b1;
                end
            end
        end
    end

    assign valid = r_valid;
    assign addr  = r_addr;
    assign dtw   = r_dtw;
    assign rw    = r_rw;
    assign rdy_f = r_rdy_f;
    assign err_f = r_err_f;
    assign dtr_f = r_dtr_f;
    assign rdy_e = r_rdy_e;
    assign err_e = r_err_e;
    assign dtr_e = r_dtr_e;

endmodule

`default_nettype wire

// File: tb/tb_hs32_mem_arbiter.sv
// ============================================================================
// Module      : tb_hs32_mem_arbiter
// Description : Directed scoreboard bench for the hs32 memory arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hs32_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_f = 1'b0;
    logic [AW-1:0] addr_f = '0;
    logic          rdy_f;
    logic [DW-1:0] dtr_f;
    logic          err_f;
    logic          flush = 1'b0;
    logic          req_e = 1'b0;
    logic          rw_e = 1'b0;
    logic [AW-1:0] addr_e = '0;
    logic [DW-1:0] dtw_e = '0;
    logic          rdy_e;
    logic [DW-1:0] dtr_e;
    logic          err_e;
    logic [AW-1:0] addr;
    logic [DW-1:0] dtw;
    logic          rw;
    logic          valid;
    logic          ready = 1'b0;
    logic [DW-1:0] dread = '0;

    always #5 clk = ~clk;

    hs32_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_f(req_f), .addr_f(addr_f), .rdy_f(rdy_f), .dtr_f(dtr_f), .err_f(err_f),
        .flush(flush),
        .req_e(req_e), .rw_e(rw_e), .addr_e(addr_e), .dtw_e(dtw_e),
        .rdy_e(rdy_e), .dtr_e(dtr_e), .err_e(err_e),
        .addr(addr), .dtw(dtw), .rw(rw), .valid(valid), .ready(ready), .dread(dread)
    );

    typedef struct packed {logic rw; logic [31:0] addr; logic [31:0] dtw;} txn_t;
    typedef struct packed {logic [31:0] data; logic err;} rsp_t;

    txn_t exp_txn[$];
    rsp_t exp_f[$];
    rsp_t exp_e[$];

    int checks = 0;
    int errors = 0;
    int n_rdy_f = 0;
    int n_rdy_e = 0;
    int lat = 0;
    int wait_cnt = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h1000) return 32'hCAFEBABE;
        return (a ^ 32'h5A5A_0000) + 32'h11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: ready after lat idle cycles; lat < 0 never answers.
    always @(negedge clk) begin
        if (!reset || !valid || ready) begin
            ready    = 1'b0;
            wait_cnt = 0;
        end else if (lat >= 0 && wait_cnt >= lat) begin
            ready = 1'b1;
            dread = mem_data(addr);
        end else begin
            wait_cnt++;
        end
    end

    logic prev_valid = 1'b0;
    txn_t cur;
    rsp_t rsp;

    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (valid && !prev_valid) begin
                if (exp_txn.size() == 0) begin
                    chk("txn_queue_size", 32'(exp_txn.size()), 32'd1);
                end else begin
                    cur = exp_txn.pop_front();
                    chk("txn_rw", 32'(rw), 32'(cur.rw));
                    chk("txn_addr", addr, cur.addr);
                    if (cur.rw) chk("txn_dtw", dtw, cur.dtw);
                end
            end else if (valid) begin
                chk("txn_addr_hold", addr, cur.addr);
            end
            prev_valid = valid;
            if (rdy_f) begin
                n_rdy_f++;
                if (exp_f.size() == 0) begin
                    chk("rdy_f_queue_size", 32'(exp_f.size()), 32'd1);
                end else begin
                    rsp = exp_f.pop_front();
                    chk("dtr_f", dtr_f, rsp.data);
                    chk("err_f", 32'(err_f), 32'(rsp.err));
                end
            end else if (err_f) begin
                chk("err_f_idle", 32'(err_f), 32'd0);
            end
            if (rdy_e) begin
                n_rdy_e++;
                if (exp_e.size() == 0) begin
                    chk("rdy_e_queue_size", 32'(exp_e.size()), 32'd1);
                end else begin
                    rsp = exp_e.pop_front();
                    chk("dtr_e", dtr_e, rsp.data);
                    chk("err_e", 32'(err_e), 32'(rsp.err));
                end
            end else if (err_e) begin
                chk("err_e_idle", 32'(err_e), 32'd0);
            end
        end
    end

    // mode: 0 normal, 1 timeout response, 2 transaction only, 3 untracked
    task automatic push_exp(input logic is_e, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input int mode);
        txn_t t;
        rsp_t s;
        t.rw = r; t.addr = a; t.dtw = d;
        s.data = (mode == 1) ? 32'h0 : mem_data(a);
        s.err  = (mode == 1);
        if (mode != 3) exp_txn.push_back(t);
        if (mode < 2) begin
            if (is_e) exp_e.push_back(s);
            else      exp_f.push_back(s);
        end
    endtask

    task automatic issue_f(input logic [31:0] a, input int mode);
        req_f = 1'b1; addr_f = a;
        push_exp(1'b0, 1'b0, a, 32'h0, mode);
        @(posedge clk); #1;
        req_f = 1'b0;
    endtask

    task automatic issue_e(input logic [31:0] a, input logic r, input logic [31:0] d, input int mode);
        req_e = 1'b1; addr_e = a; rw_e = r; dtw_e = d;
        push_exp(1'b1, r, a, d, mode);
        @(posedge clk); #1;
        req_e = 1'b0;
    endtask

    // Both in one cycle with last_grant = FETCH: exec goes first.
    task automatic issue_both(input logic [31:0] fa, input logic [31:0] ea,
                              input logic r, input logic [31:0] d);
        req_f = 1'b1; addr_f = fa;
        req_e = 1'b1; addr_e = ea; rw_e = r; dtw_e = d;
        push_exp(1'b1, r, ea, d, 0);
        push_exp(1'b0, 1'b0, fa, 32'h0, 0);
        @(posedge clk); #1;
        req_f = 1'b0; req_e = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (exp_txn.size() == 0 && exp_f.size() == 0 && exp_e.size() == 0 && !valid) break;
            @(posedge clk); #2;
        end
        chk(tag, 32'(exp_txn.size() + exp_f.size() + exp_e.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        int bf, be, se, sf, issued, vcnt;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rdy_f", 32'(rdy_f), 32'd0);
        chk("rst_rdy_e", 32'(rdy_e), 32'd0);
        chk("rst_err_f", 32'(err_f), 32'd0);
        chk("rst_err_e", 32'(err_e), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_dtr_f", dtr_f, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Single fetch and its latency
        issue_f(32'h1000, 0);
        @(negedge clk);
        chk("lat_valid_early", 32'(valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(valid), 32'd1);
        chk("lat_addr", addr, 32'h1000);
        chk("lat_rw", 32'(rw), 32'd0);
        @(negedge clk);
        chk("single_rdy_f", 32'(rdy_f), 32'd1);
        chk("single_dtr_f", dtr_f, 32'hCAFEBABE);
        @(negedge clk);
        chk("single_rdy_f_pulse", 32'(rdy_f), 32'd0);
        chk("single_dtr_f_hold", dtr_f, 32'hCAFEBABE);
        wait_idle("drain_single", 20);

        // Simultaneous requests: exec write first
        issue_both(32'h1004, 32'h0010, 1'b1, 32'hAAAA0000);
        wait_idle("drain_simul", 30);

        // Fairness: re-request on every response
        bf = n_rdy_f; be = n_rdy_e; sf = n_rdy_f; se = n_rdy_e;
        issue_both(32'h400, 32'h300, 1'b0, 32'h0);
        issued = 2;
        for (int c = 0; c < 200 && ((n_rdy_f - bf) + (n_rdy_e - be)) < 8; c++) begin
            @(posedge clk); #1;
            if (n_rdy_e > se) begin
                se = n_rdy_e;
                if (issued < 8) begin
                    issue_e(32'h300 + 32'(issued * 4), 1'(issued >> 1), 32'hB000_0000 + 32'(issued), 0);
                    issued++;
                end
            end
            if (n_rdy_f > sf) begin
                sf = n_rdy_f;
                if (issued < 8) begin
                    issue_f(32'h400 + 32'(issued * 4), 0);
                    issued++;
                end
            end
        end
        chk("fair_rdy_f_count", 32'(n_rdy_f - bf), 32'd4);
        chk("fair_rdy_e_count", 32'(n_rdy_e - be), 32'd4);
        wait_idle("drain_fair", 30);

        // Flush of an in-flight fetch
        lat = 3;
        issue_f(32'h2000, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("flush_rdy_f", 32'(rdy_f), 32'd0);
            if (i < 2) chk("flush_valid_hold", 32'(valid), 32'd1);
            if (i == 2) chk("flush_valid_done", 32'(valid), 32'd0);
        end
        lat = 0;
        @(posedge clk); #1;
        issue_f(32'h2004, 0);
        wait_idle("drain_flush", 20);

        // Timeout on an exec read
        lat = -1;
        issue_e(32'h500, 1'b0, 32'h0, 1);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        chk("timeout_valid_cycles", 32'(vcnt), 32'd8);
        lat = 0;
        @(posedge clk); #1;
        issue_e(32'h504, 1'b0, 32'h0, 0);
        wait_idle("drain_timeout", 20);

        // Reset in the middle of a transaction
        lat = -1;
        issue_f(32'h3000, 2);
        issue_e(32'h600, 1'b0, 32'h0, 3);
        @(negedge clk);
        chk("midrst_valid_before", 32'(valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_rdy_f", 32'(rdy_f), 32'd0);
        chk("midrst_rdy_e", 32'(rdy_e), 32'd0);
        chk("midrst_err_f", 32'(err_f), 32'd0);
        chk("midrst_err_e", 32'(err_e), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        lat = 0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("postrst_valid", 32'(valid), 32'd0);
            chk("postrst_rdy", 32'({rdy_f, rdy_e}), 32'd0);
        end
        @(posedge clk); #1;
        issue_both(32'h3008, 32'h0700, 1'b1, 32'h1234_5678);
        wait_idle("drain_postrst", 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hs32_mem_arbiter.md
Name: hs32_mem_arbiter

Overview:
- Shares the single SoC memory port (bram controller valid/ready interface) between the instruction fetch path and the execute unit's load/store path.
- Latches one request per requester, picks a winner, sequences exactly one downstream transaction at a time and routes the response back.
- Handles pipeline flush of in-flight fetches and times out hung transactions.
- Sits between hs32_fetch/hs32_exec and soc_bram_ctl.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles valid may wait for ready (0 = timeout disabled)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_f  in  1  fetch request pulse (one cycle)
- addr_f  in  AW  fetch address, sampled with req_f
- rdy_f  out  1  fetch response pulse
- dtr_f  out  DW  fetch read data, valid with rdy_f
- err_f  out  1  fetch timeout flag, valid with rdy_f
- flush  in  1  discard outstanding fetch
- req_e  in  1  exec request pulse (one cycle)
- rw_e  in  1  1 = write, 0 = read
- addr_e  in  AW  exec address
- dtw_e  in  DW  exec write data
- rdy_e  out  1  exec response pulse
- dtr_e  out  DW  exec read data
- err_e  out  1  exec timeout flag
- addr  out  AW  memory address
- dtw  out  DW  memory write data
- rw  out  1  memory write enable
- valid  out  1  memory request
- ready  in  1  memory done
- dread  in  DW  memory read data

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, both pending slots empty, state IDLE, last_grant = FETCH.
  - Reset mid-transaction abandons the transaction with no response.
- Pending slots, one per requester:
  - req_x loads addr/rw/data into slot x and sets pend_x.
  - req_x while pend_x set or while x is in flight is ignored; first request wins.
- State IDLE:
  - If any pend_x is set (including one set this cycle, forwarded), grant.
  - Both pending: grant the requester not in last_grant. Otherwise grant whichever is pending.
  - On grant: next cycle valid=1, addr/rw/dtw driven from the slot (fetch forces rw=0), pend_x cleared, last_grant updated, state BUSY.
  - Latency: req_x sampled at edge N -> valid high after edge N+1.
- State BUSY:
  - valid, addr, rw and dtw stay stable until ready is sampled high.
  - On ready: valid=0, rdy_x=1 for one cycle, dtr_x=dread registered, err_x=0, state IDLE.
  - A new grant is possible on the following cycle, giving a minimum 2-cycle turnaround per transaction.
- Timeout:
  - The counter resets on entering BUSY and increments each BUSY cycle without ready.
  - When the count reaches TIMEOUT (TIMEOUT>0): valid=0, rdy_x=1, err_x=1, dtr_x=0, state IDLE.
  - ready arriving in the same cycle as expiry takes precedence and completes normally.
- flush:
  - Clears pend_f.
  - If a fetch is in flight, the downstream transaction still completes (or times out), but rdy_f/err_f are suppressed.
  - req_f in the same cycle as flush is accepted and not flushed.
  - flush does not affect exec.
- Idle outputs:
  - rdy_x and err_x are 0 except for the single-cycle response pulse.
  - dtr_x holds its last value.

Decomposition:
- Shared include cpu/hs32_memarb_defs.v holds:
  - state encodings IDLE=1'b0, BUSY=1'b1
  - grant encodings GNT_F=1'b0, GNT_E=1'b1
- One natural sub-module, hs32_memarb_slot: a one-deep pending-request latch with load, clear and drop inputs, instantiated once per requester.

Test Plan:
- Single fetch: reset released, req_f with addr_f=0x1000, ready=1, dread=0xCAFEBABE -> valid=1 and addr=0x1000 one cycle after the req_f edge; rdy_f pulses the next cycle with dtr_f=0xCAFEBABE and err_f=0.
- Simultaneous requests after reset (last_grant=FETCH): req_f addr 0x1004 plus req_e write addr 0x0010, dtw_e=0xAAAA0000 -> first transaction is rw=1, addr=0x0010, dtw=0xAAAA0000; rdy_e; then the fetch at 0x1004; rdy_f.
- Fairness: both requesters re-request on every response for 8 transactions -> grants strictly alternate E,F,E,F...; no rdy_x pulse is ever missing.
- Flush: fetch to 0x2000 in flight, ready delayed 3 cycles, flush pulsed in the 2nd BUSY cycle -> valid held until ready; rdy_f never asserts; a subsequent req_f to 0x2004 completes normally.
- Timeout: TIMEOUT=8, exec read with ready held 0 -> valid high exactly 8 cycles, then rdy_e=1, err_e=1, dtr_e=0; the next request is granted normally.
- Reset mid-transaction: reset driven low while valid=1 -> valid, rdy_f, rdy_e and err_x go 0 without waiting for a clock edge; after release no stale response appears and pend_f/pend_e are empty.
